inst_fetch: RTL and testbench

- Instruction-fetch front end of the openmips core.
- Generates the PC and drives the instruction ROM port (rom_ce_o, rom_addr_o, rom_data_i).
- Registers the fetched word into an IF/ID pipeline register for the decode stage.
- Handles stall, branch redirect (with a pending-branch latch while stalled) and exception flush.

---
 rtl/inst_fetch_pkg.sv | 37 +++
 rtl/inst_fetch_pc_gen.sv | 61 ++++++
 rtl/inst_fetch.sv | 65 ++++++
 tb/tb_inst_fetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants and PC-source selection for the inst_fetch front end.
// Reset is active-low, so the asserted level is 1'b0.
package inst_fetch_pkg;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    typedef enum logic [2:0] {
        PC_IDLE,
        PC_FLUSH,
        PC_STALL,
        PC_PEND,
        PC_BRANCH,
        PC_SEQ
    } pc_sel_t;

    // Priority order for the next-PC source: flush beats stall, a pending
    // branch beats a fresh one, and sequential fetch is the fallback.
    function automatic pc_sel_t pc_select(
        input logic ce,
        input logic flush,
        input logic stall,
        input logic pend_v,
        input logic branch
    );
        if (ce != CHIP_ENABLE) return PC_IDLE;
        if (flush)             return PC_FLUSH;
        if (stall == STOP)     return PC_STALL;
        if (pend_v)            return PC_PEND;
        if (branch)            return PC_BRANCH;
        return PC_SEQ;
    endfunction

endpackage

// File: rtl/inst_fetch_pc_gen.sv
// PC register, ROM chip enable and the branch latch that remembers a
// redirect resolved while fetch was stalled.
module inst_fetch_pc_gen
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              ce,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pend_tgt_reg;
    logic              pend_v_reg;
    logic [ADDR_W-1:0] branch_aligned;
    logic [ADDR_W-1:0] flush_aligned;
    pc_sel_t           sel;

    assign branch_aligned = {branch_target_i[ADDR_W-1:2], 2'b00};
    assign flush_aligned  = {flush_pc_i[ADDR_W-1:2], 2'b00};
    assign sel = pc_select(ce, flush_i, stall_if_i, pend_v_reg, branch_flag_i);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            ce           <= CHIP_DISABLE;
            pc           <= RESET_PC[ADDR_W-1:0];
            pend_v_reg   <= 1'b0;
            pend_tgt_reg <= '0;
        end else begin
            ce <= CHIP_ENABLE;
            case (sel)
                PC_IDLE: pc <= RESET_PC[ADDR_W-1:0];
                PC_FLUSH: begin
                    pc         <= flush_aligned;
                    pend_v_reg <= 1'b0;
                end
                PC_STALL: begin
                    // Last branch seen during the stall wins.
                    if (branch_flag_i) begin
                        pend_tgt_reg <= branch_aligned;
                        pend_v_reg   <= 1'b1;
                    end
                end
                PC_PEND: begin
                    pc         <= pend_tgt_reg;
                    pend_v_reg <= 1'b0;
                end
                PC_BRANCH: pc <= branch_aligned;
                default:   pc <= pc + ADDR_W'(4);
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the instruction ROM from the PC generator
// and registers the fetched word into the IF/ID pipeline register.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if_i,
    input  logic              stall_id_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    logic [ADDR_W-1:0] pc;
    logic              bubble;

    inst_fetch_pc_gen #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_pc_gen (
        .clk             (clk),
        .rst             (rst),
        .stall_if_i      (stall_if_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .ce              (rom_ce_o),
        .pc              (pc)
    );

    assign rom_addr_o = pc;
    assign bubble     = flush_i || (stall_if_i == STOP && stall_id_i == NO_STOP);

    // A downstream stall holds IF/ID; an upstream-only stall inserts a NOP.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            id_pc_o    <= '0;
            id_inst_o  <= NOP_INST[INST_W-1:0];
            id_valid_o <= 1'b0;
        end else if (bubble) begin
            id_pc_o    <= '0;
            id_inst_o  <= NOP_INST[INST_W-1:0];
            id_valid_o <= 1'b0;
        end else if (stall_id_i == NO_STOP) begin
            id_pc_o    <= pc;
            id_inst_o  <= rom_data_i;
            id_valid_o <= rom_ce_o;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; the ROM returns (word index + 1) so every
// fetched word identifies its own address.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if_i = 1'b0;
    logic        stall_id_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    int errors = 0;
    int checks = 0;

    logic [97:0] obs;
    assign obs = {rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o};

    assign rom_data_i = {2'b00, rom_addr_o[31:2]} + 32'd1;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_if_i      (stall_if_i),
        .stall_id_i      (stall_id_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_data_i      (rom_data_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o)
    );

    always @(posedge clk) begin
        if (rst) assert (!(stall_id_i && !stall_if_i))
            else $error("illegal stall: stall_id_i without stall_if_i");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs, {1'b0, 32'h0, 32'h0, 32'h0, 1'b0});
        end
        $display("reset: ce=%b addr=%h id=%h/%h v=%b", rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
        @(posedge clk); #1; rst = 1'b1;
    endtask

    task automatic test_seq_fetch();
        logic [97:0] exp_v [3];
        exp_v[0] = {1'b1, 32'h0, 32'h0, 32'h1, 1'b0};
        exp_v[1] = {1'b1, 32'h4, 32'h0, 32'h1, 1'b1};
        exp_v[2] = {1'b1, 32'h8, 32'h4, 32'h2, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL seq_fetch[%0d] got=%h exp=%h", i, obs, exp_v[i]);
            end
            $display("seq: addr=%h id_pc=%h inst=%h v=%b", rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
        end
    endtask

    task automatic test_branch();
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0043;
        step();
        branch_flag_i = 1'b0;
        checks++;
        if (obs !== {1'b1, 32'h40, 32'h8, 32'h3, 1'b1}) begin
            errors++;
            $display("FAIL branch_redirect got=%h exp=%h", obs, {1'b1, 32'h40, 32'h8, 32'h3, 1'b1});
        end
        $display("branch: addr=%h id_pc=%h inst=%h", rom_addr_o, id_pc_o, id_inst_o);
        step();
        checks++;
        if (obs !== {1'b1, 32'h44, 32'h40, 32'h11, 1'b1}) begin
            errors++;
            $display("FAIL branch_target_fetch got=%h exp=%h", obs, {1'b1, 32'h44, 32'h40, 32'h11, 1'b1});
        end
        $display("branch: addr=%h id_pc=%h inst=%h", rom_addr_o, id_pc_o, id_inst_o);
    endtask

    task automatic test_full_stall();
        branch_flag_i = 1'b1; branch_target_i = 32'h10;
        step();
        branch_flag_i = 1'b0;
        stall_if_i = 1'b1; stall_id_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== {1'b1, 32'h10, 32'h44, 32'h12, 1'b1}) begin
                errors++;
                $display("FAIL full_stall[%0d] got=%h exp=%h", i, obs, {1'b1, 32'h10, 32'h44, 32'h12, 1'b1});
            end
            $display("stall: addr=%h id_pc=%h inst=%h", rom_addr_o, id_pc_o, id_inst_o);
        end
        stall_if_i = 1'b0; stall_id_i = 1'b0;
        step();
        checks++;
        if (obs !== {1'b1, 32'h14, 32'h10, 32'h5, 1'b1}) begin
            errors++;
            $display("FAIL stall_release got=%h exp=%h", obs, {1'b1, 32'h14, 32'h10, 32'h5, 1'b1});
        end
        $display("release: addr=%h id_pc=%h inst=%h", rom_addr_o, id_pc_o, id_inst_o);
    endtask

    task automatic test_bubble();
        stall_if_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== {1'b1, 32'h14, 32'h0, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL bubble[%0d] got=%h exp=%h", i, obs, {1'b1, 32'h14, 32'h0, 32'h0, 1'b0});
            end
            $display("bubble: addr=%h id_pc=%h inst=%h v=%b", rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
        end
        stall_if_i = 1'b0;
        step();
        checks++;
        if (obs !== {1'b1, 32'h18, 32'h14, 32'h6, 1'b1}) begin
            errors++;
            $display("FAIL bubble_release got=%h exp=%h", obs, {1'b1, 32'h18, 32'h14, 32'h6, 1'b1});
        end
        $display("release: addr=%h id_pc=%h inst=%h", rom_addr_o, id_pc_o, id_inst_o);
    endtask

    task automatic test_pending_branch();
        stall_if_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h200;
        step();
        branch_target_i = 32'h101;
        step();
        checks++;
        if (obs !== {1'b1, 32'h18, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL pend_frozen got=%h exp=%h", obs, {1'b1, 32'h18, 32'h0, 32'h0, 1'b0});
        end
        $display("pend: addr=%h v=%b", rom_addr_o, id_valid_o);
        stall_if_i = 1'b0; branch_flag_i = 1'b0;
        step();
        checks++;
        if (obs !== {1'b1, 32'h100, 32'h18, 32'h7, 1'b1}) begin
            errors++;
            $display("FAIL pend_redirect got=%h exp=%h", obs, {1'b1, 32'h100, 32'h18, 32'h7, 1'b1});
        end
        $display("pend: addr=%h id_pc=%h inst=%h", rom_addr_o, id_pc_o, id_inst_o);
        step();
        checks++;
        if (rom_addr_o !== 32'h104) begin
            errors++;
            $display("FAIL pend_cleared got=%h exp=%h", rom_addr_o, 32'h104);
        end
        $display("pend: addr=%h", rom_addr_o);
    endtask

    task automatic test_flush();
        flush_i = 1'b1; flush_pc_i = 32'h183;
        branch_flag_i = 1'b1; branch_target_i = 32'h300; stall_if_i = 1'b1;
        step();
        flush_i = 1'b0; branch_flag_i = 1'b0; stall_if_i = 1'b0;
        checks++;
        if (obs !== {1'b1, 32'h180, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL flush got=%h exp=%h", obs, {1'b1, 32'h180, 32'h0, 32'h0, 1'b0});
        end
        $display("flush: addr=%h id_pc=%h inst=%h v=%b", rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
        step();
        checks++;
        if (obs !== {1'b1, 32'h184, 32'h180, 32'h61, 1'b1}) begin
            errors++;
            $display("FAIL flush_no_pend got=%h exp=%h", obs, {1'b1, 32'h184, 32'h180, 32'h61, 1'b1});
        end
        $display("flush: addr=%h id_pc=%h inst=%h", rom_addr_o, id_pc_o, id_inst_o);
    endtask

    task automatic test_wrap();
        flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
        step();
        flush_i = 1'b0;
        step();
        checks++;
        if (obs !== {1'b1, 32'h0, 32'hFFFF_FFFC, 32'h4000_0000, 1'b1}) begin
            errors++;
            $display("FAIL wrap got=%h exp=%h", obs, {1'b1, 32'h0, 32'hFFFF_FFFC, 32'h4000_0000, 1'b1});
        end
        $display("wrap: addr=%h id_pc=%h inst=%h", rom_addr_o, id_pc_o, id_inst_o);
    endtask

    task automatic test_reset_midstream();
        stall_if_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h200;
        step();
        branch_flag_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", obs, {1'b0, 32'h0, 32'h0, 32'h0, 1'b0});
        end
        $display("midreset: ce=%b addr=%h v=%b", rom_ce_o, rom_addr_o, id_valid_o);
        stall_if_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (obs !== {1'b1, 32'h0, 32'h0, 32'h1, 1'b0}) begin
            errors++;
            $display("FAIL restart_ce got=%h exp=%h", obs, {1'b1, 32'h0, 32'h0, 32'h1, 1'b0});
        end
        $display("restart: ce=%b addr=%h", rom_ce_o, rom_addr_o);
        step();
        checks++;
        if (obs !== {1'b1, 32'h4, 32'h0, 32'h1, 1'b1}) begin
            errors++;
            $display("FAIL restart_no_pend got=%h exp=%h", obs, {1'b1, 32'h4, 32'h0, 32'h1, 1'b1});
        end
        $display("restart: addr=%h id_pc=%h inst=%h", rom_addr_o, id_pc_o, id_inst_o);
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_branch();
        test_full_stall();
        test_bubble();
        test_pending_branch();
        test_flush();
        test_wrap();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
